// File: rtl/ms_timer_bank.sv
// Bank of CHANNELS independent millisecond timers with start/idle/valid handshakes.
// Optional per-channel abort of running calls when MS_TIMER_BANK_CANCEL_EN is defined.
module ms_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int MS_W     = 32,
    parameter int CLK_HZ   = 12000000
) (
    input  logic                     __clk,
    input  logic                     __reset,
    input  logic [CHANNELS*MS_W-1:0] __p_ms,
    input  logic [CHANNELS-1:0]      __start,
`ifdef MS_TIMER_BANK_CANCEL_EN
    input  logic [CHANNELS-1:0]      __cancel,
`endif
    output logic [CHANNELS-1:0]      __idle,
    output logic [CHANNELS-1:0]      __valid
);

    localparam int D     = CLK_HZ / 1000;
    localparam int SUB_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(D - 1);

    if ((CLK_HZ % 1000) != 0 || D < 1) begin : g_bad_clk
        $error("ms_timer_bank: CLK_HZ must be a positive multiple of 1000");
    end

    typedef enum logic {IDLE, RUN} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t            state;
        logic [SUB_W-1:0]  sub;
        logic [MS_W-1:0]   rem;
        logic              zero_pend;
        logic              idle_r;
        logic              valid_r;
        logic              cancel;

`ifdef MS_TIMER_BANK_CANCEL_EN
        assign cancel = __cancel[i];
`else
        assign cancel = 1'b0;
`endif

        always_ff @(posedge __clk) begin
            if (__reset) begin
                state     <= IDLE;
                sub       <= '0;
                rem       <= '0;
                zero_pend <= 1'b0;
                idle_r    <= 1'b1;
                valid_r   <= 1'b0;
            end else begin
                valid_r   <= 1'b0;
                zero_pend <= 1'b0;
                case (state)
                    IDLE: begin
                        // A zero-length call completes one edge after acceptance.
                        if (zero_pend)
                            valid_r <= 1'b1;
                        if (__start[i]) begin
                            rem <= __p_ms[i*MS_W +: MS_W];
                            sub <= '0;
                            if (__p_ms[i*MS_W +: MS_W] == '0) begin
                                zero_pend <= 1'b1;
                            end else begin
                                state  <= RUN;
                                idle_r <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (cancel) begin
                            state  <= IDLE;
                            idle_r <= 1'b1;
                            sub    <= '0;
                            rem    <= '0;
                        end else if (sub == SUB_LAST) begin
                            sub <= '0;
                            rem <= rem - MS_W'(1);
                            if (rem == MS_W'(1)) begin
                                state   <= IDLE;
                                idle_r  <= 1'b1;
                                valid_r <= 1'b1;
                            end
                        end else begin
                            sub <= sub + SUB_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign __idle[i]  = idle_r;
        assign __valid[i] = valid_r;
    end

endmodule
